// File: rtl/div2or3_modulus_ctrl.sv
// Pulse-swallow modulus controller for one divide-by-2/3 prescaler cell.
// Optional fractional swallow accumulator: define DIVCTRL_FRAC_EN.
module div2or3_modulus_ctrl #(
  parameter int W      = 8,
  parameter int P_RST  = 4,
  parameter int FRAC_W = 8
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              en,
  input  logic              load,
  input  logic [W-1:0]      p_val,
  input  logic [W-1:0]      s_val,
`ifdef DIVCTRL_FRAC_EN
  input  logic [FRAC_W-1:0] frac_val,
`endif
  output logic              mod_out,
  output logic              div_out,
  output logic              tc,
  output logic              busy,
  output logic              cfg_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam logic [W-1:0] ONE  = W'(1);
  localparam logic [W-1:0] TWO  = W'(2);
  localparam logic [W:0]   ONE1 = (W+1)'(1);

  state_t       state, state_nxt;
  logic [W-1:0] cnt, cnt_nxt;
  logic [W-1:0] p_act, s_act, p_nxt, s_nxt;
  logic [W-1:0] p_sh, s_sh;
  logic         pending, pending_nxt;
  logic         wrap, start, apply, load_ok;
  logic [W:0]   s_eff_nxt;
  logic         mod_nxt, div_nxt, tc_nxt, busy_nxt, err_nxt;

`ifdef DIVCTRL_FRAC_EN
  logic [FRAC_W-1:0] acc, acc_nxt;
  logic              cy, cy_nxt;
  logic [FRAC_W:0]   acc_sum;
`endif

  // State register
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN:     if (!en) state_nxt = STOP;
      STOP:    if (en) state_nxt = RUN;
               else if (wrap) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counter, shadow config and apply point
  always_comb begin
    wrap  = (state != IDLE) && (cnt == p_act - ONE);
    start = (state == IDLE) && en;
    apply = (wrap || start) && pending;
`ifdef DIVCTRL_FRAC_EN
    load_ok = load && (p_val >= TWO) && (s_val < p_val);
`else
    load_ok = load && (p_val >= TWO) && (s_val <= p_val);
`endif
    err_nxt     = load && !load_ok;
    pending_nxt = load_ok || (pending && !apply);
    cnt_nxt     = (state == IDLE || wrap) ? '0 : cnt + ONE;
    p_nxt       = apply ? p_sh : p_act;
    s_nxt       = apply ? s_sh : s_act;
  end

`ifdef DIVCTRL_FRAC_EN
  // Carry out of the wrap-time add swallows one extra pulse next period
  always_comb begin
    acc_sum = {1'b0, acc} + {1'b0, frac_val};
    acc_nxt = acc;
    cy_nxt  = cy;
    if (start) begin
      acc_nxt = '0;
      cy_nxt  = 1'b0;
    end else if (wrap) begin
      acc_nxt = acc_sum[FRAC_W-1:0];
      cy_nxt  = acc_sum[FRAC_W];
    end
    s_eff_nxt = {1'b0, s_nxt} + {{W{1'b0}}, cy_nxt};
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cy  <= 1'b0;
    end else begin
      acc <= acc_nxt;
      cy  <= cy_nxt;
    end
  end
`else
  always_comb s_eff_nxt = {1'b0, s_nxt};
`endif

  // Outputs are decoded from next-cnt so they line up with cnt
  always_comb begin
    busy_nxt = (state_nxt != IDLE);
    mod_nxt  = busy_nxt && ({1'b0, cnt_nxt} < s_eff_nxt);
    div_nxt  = busy_nxt &&
               ({1'b0, cnt_nxt} < (({1'b0, p_nxt} + ONE1) >> 1));
    tc_nxt   = busy_nxt && (cnt_nxt == p_nxt - ONE);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      p_act   <= W'(P_RST);
      s_act   <= '0;
      p_sh    <= W'(P_RST);
      s_sh    <= '0;
      pending <= 1'b0;
      mod_out <= 1'b0;
      div_out <= 1'b0;
      tc      <= 1'b0;
      busy    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      p_act   <= p_nxt;
      s_act   <= s_nxt;
      pending <= pending_nxt;
      if (load_ok) begin
        p_sh <= p_val;
        s_sh <= s_val;
      end
      mod_out <= mod_nxt;
      div_out <= div_nxt;
      tc      <= tc_nxt;
      busy    <= busy_nxt;
      cfg_err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_div2or3_modulus_ctrl.sv
// Directed bench for div2or3_modulus_ctrl (default build).
// Expected values are hand-derived per clk_in cycle.
module tb_div2or3_modulus_ctrl;

  localparam int W = 8;

  logic         clk_in = 1'b0;
  logic         rst_n;
  logic         en;
  logic         load;
  logic [W-1:0] p_val;
  logic [W-1:0] s_val;
`ifdef DIVCTRL_FRAC_EN
  logic [7:0]   frac_val;
`endif
  logic         mod_out;
  logic         div_out;
  logic         tc;
  logic         busy;
  logic         cfg_err;

  int n_cmp = 0;
  int n_err = 0;
  int pre_cnt;

  always #5 clk_in = ~clk_in;

  div2or3_modulus_ctrl #(
    .W(W),
    .P_RST(4),
    .FRAC_W(8)
  ) dut (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .en      (en),
    .load    (load),
    .p_val   (p_val),
    .s_val   (s_val),
`ifdef DIVCTRL_FRAC_EN
    .frac_val(frac_val),
`endif
    .mod_out (mod_out),
    .div_out (div_out),
    .tc      (tc),
    .busy    (busy),
    .cfg_err (cfg_err)
  );

  task automatic cmp(input string tag, input string sig,
                     input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s %s observed=%b expected=%b", tag, sig, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic m, input logic d,
                     input logic t, input logic b, input logic e);
    cmp(tag, "mod_out", mod_out, m);
    cmp(tag, "div_out", div_out, d);
    cmp(tag, "tc", tc, t);
    cmp(tag, "busy", busy, b);
    cmp(tag, "cfg_err", cfg_err, e);
  endtask

  task automatic step(input string tag, input logic m, input logic d,
                      input logic t, input logic b, input logic e);
    @(posedge clk_in);
    #1;
    chk(tag, m, d, t, b, e);
  endtask

  task automatic set_load(input logic l, input int p, input int s);
    load  = l;
    p_val = W'(p);
    s_val = W'(s);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    set_load(1'b0, 0, 0);
`ifdef DIVCTRL_FRAC_EN
    frac_val = '0;
`endif
    #2;
    chk("reset", 0, 0, 0, 0, 0);
    @(posedge clk_in);
    #1;
    rst_n = 1'b1;
    step("idle", 0, 0, 0, 0, 0);

    // P=4, S=0
    en = 1'b1;
    for (int r = 0; r < 2; r++) begin
      step("p4_c0", 0, 1, 0, 1, 0);
      step("p4_c1", 0, 1, 0, 1, 0);
      step("p4_c2", 0, 0, 0, 1, 0);
      step("p4_c3", 0, 0, 1, 1, 0);
    end

    // Mid-period load p=5 s=2: old period completes first
    step("p4_c0b", 0, 1, 0, 1, 0);
    set_load(1'b1, 5, 2);
    step("ld5_c1", 0, 1, 0, 1, 0);
    set_load(1'b0, 0, 0);
    step("ld5_c2", 0, 0, 0, 1, 0);
    step("ld5_c3", 0, 0, 1, 1, 0);
    for (int r = 0; r < 2; r++) begin
      pre_cnt = 0;
      step("p5_c0", 1, 1, 0, 1, 0); pre_cnt += 2 + int'(mod_out);
      step("p5_c1", 1, 1, 0, 1, 0); pre_cnt += 2 + int'(mod_out);
      step("p5_c2", 0, 1, 0, 1, 0); pre_cnt += 2 + int'(mod_out);
      step("p5_c3", 0, 0, 0, 1, 0); pre_cnt += 2 + int'(mod_out);
      step("p5_c4", 0, 0, 1, 1, 0); pre_cnt += 2 + int'(mod_out);
      n_cmp++;
      assert (pre_cnt == 12) else begin
        n_err++;
        $error("FAIL p5_input_cycles observed=%0d expected=12", pre_cnt);
      end
    end

    // Invalid load (s > p) on a wrap edge: error pulse, config kept
    set_load(1'b1, 3, 4);
    step("bad_c0", 1, 1, 0, 1, 1);
    set_load(1'b0, 0, 0);
    step("bad_c1", 1, 1, 0, 1, 0);
    set_load(1'b1, 2, 2);
    step("bad_c2", 0, 1, 0, 1, 0);
    set_load(1'b0, 0, 0);
    step("bad_c3", 0, 0, 0, 1, 0);
    step("bad_c4", 0, 0, 1, 1, 0);

    // P=2, S=P: mod held high, tc every other cycle
    for (int r = 0; r < 3; r++) begin
      step("p2_c0", 1, 1, 0, 1, 0);
      step("p2_c1", 1, 0, 1, 1, 0);
    end

    // Load coincident with wrap is deferred one period
    set_load(1'b1, 5, 2);
    step("wrapld_c0", 1, 1, 0, 1, 0);
    set_load(1'b0, 0, 0);
    step("wrapld_c1", 1, 0, 1, 1, 0);
    step("stop_c0", 1, 1, 0, 1, 0);

    // en low at cnt=1: finish the period then idle
    step("stop_c1", 1, 1, 0, 1, 0);
    en = 1'b0;
    step("stop_c2", 0, 1, 0, 1, 0);
    step("stop_c3", 0, 0, 0, 1, 0);
    step("stop_c4", 0, 0, 1, 1, 0);
    step("stop_idle", 0, 0, 0, 0, 0);
    step("stop_idle2", 0, 0, 0, 0, 0);

    // Second run, en re-raised at cnt=3: no idle gap
    en = 1'b1;
    step("rerun_c0", 1, 1, 0, 1, 0);
    step("rerun_c1", 1, 1, 0, 1, 0);
    en = 1'b0;
    step("rerun_c2", 0, 1, 0, 1, 0);
    step("rerun_c3", 0, 0, 0, 1, 0);
    en = 1'b1;
    step("rerun_c4", 0, 0, 1, 1, 0);
    step("rerun_w0", 1, 1, 0, 1, 0);
    step("rerun_w1", 1, 1, 0, 1, 0);

    // Pending load p=7 s=3 then async reset at cnt=3
    set_load(1'b1, 7, 3);
    step("rst_c2", 0, 1, 0, 1, 0);
    set_load(1'b0, 0, 0);
    step("rst_c3", 0, 0, 0, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", 0, 0, 0, 0, 0);
    @(posedge clk_in);
    #1;
    chk("rst_hold", 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Restart uses P_RST=4, S=0; pending load discarded
    for (int r = 0; r < 2; r++) begin
      step("rst_p4_c0", 0, 1, 0, 1, 0);
      step("rst_p4_c1", 0, 1, 0, 1, 0);
      step("rst_p4_c2", 0, 0, 0, 1, 0);
      step("rst_p4_c3", 0, 0, 1, 1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/div2or3_modulus_ctrl.md
Name: div2or3_modulus_ctrl

Overview:
- Pulse-swallow controller for one divide-by-2/3 prescaler cell. It runs on the prescaler output clock and drives the cell's mod input (1 = divide by 3, 0 = divide by 2).
- Yields total division N = 2*P + S from the prescaler input clock, with S <= P.
- Holds shadow configuration with glitch-free update at period boundaries. Emits a divided output and a terminal-count pulse.

Parameters:
- W, 8, width of P and S counters/config.
- P_RST, 4, P value applied out of reset (S out of reset = 0).
- FRAC_W, 8, accumulator width (only used with DIVCTRL_FRAC_EN).

Ports:
- clk_in  input  1  prescaler output clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  run enable.
- load  input  1  one-cycle strobe to capture p_val/s_val into shadow.
- p_val  input  W  requested program count P (valid 2..2^W-1).
- s_val  input  W  requested swallow count S (valid 0..P).
- frac_val  input  FRAC_W  fractional increment (present only with DIVCTRL_FRAC_EN).
- mod_out  output  1  to prescaler mod; 1 = divide by 3.
- div_out  output  1  divided clock, high for cnt < ceil(P/2).
- tc  output  1  one-cycle pulse in the last cycle of each period.
- busy  output  1  high in RUN or STOP.
- cfg_err  output  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, cnt=0, p_act=P_RST, s_act=0, pending=0.
  - All outputs 0. Accumulator 0.
  - Reset mid-period aborts immediately. No partial-period completion.
- States:
  - IDLE: cnt held at 0; mod_out=0, div_out=0, tc=0. en=1 -> RUN next edge. If pending=1 at that point, shadow is copied to p_act/s_act on that edge and pending is cleared.
  - RUN: cnt increments each edge and wraps P_act-1 -> 0. en=0 -> STOP.
  - STOP: continue counting until wrap, then IDLE. en=1 again before wrap -> back to RUN with no disturbance to counting.
- All outputs are registered. For a cycle in which cnt=k:
  - mod_out=1 iff k < s_act.
  - div_out=1 iff k < ceil(p_act/2).
  - tc=1 iff k = p_act-1.
  - Outputs reflect cnt with zero added latency: each is computed from the next-cnt value.
- Period = p_act clk_in cycles = 2*p_act + s_act prescaler input cycles.
- Load handling:
  - load=1 with 2 <= p_val and s_val <= p_val: copy p_val/s_val into shadow and set pending.
  - A later valid load before the boundary overwrites the shadow. Last write wins.
  - Invalid load: shadow unchanged, cfg_err pulses for one cycle on the next edge.
- Apply point: p_act/s_act update only on the wrap edge (cnt P_act-1 -> 0) or on IDLE->RUN, and pending clears there.
  - load coincident with the wrap edge is not applied at that wrap. It is applied at the following wrap.
- Edge values:
  - s_act=0: mod_out never asserts.
  - s_act=p_act: mod_out held 1 for the whole period.
  - p_act=2: div_out 1,0 pattern; tc every second cycle.
- cnt width W, unsigned. All comparisons unsigned.

Optional Feature:
- Macro: DIVCTRL_FRAC_EN.
- When defined:
  - frac_val port exists. Accumulator acc (FRAC_W bits) updates on every wrap edge: acc <= acc + frac_val mod 2^FRAC_W.
  - The carry from that add sets s_eff = s_act + 1 for the next period, otherwise s_eff = s_act.
  - mod_out uses s_eff instead of s_act.
  - Load validity tightens to s_val <= p_val-1.
  - acc clears on reset and on IDLE->RUN.
  - Average division = 2P + S + frac_val/2^FRAC_W.
- When undefined: no frac_val port, no accumulator; s_eff = s_act.

Test Plan:
- Reset, then en=1 with P_RST=4, S=0 -> mod_out always 0, tc every 4th clk_in, div_out 1,1,0,0 repeating; busy=1 the edge after en.
- load p=5, s=2 mid-period -> old pattern completes. From the next wrap: mod_out 1,1,0,0,0 per period, tc period 5; prescaler-input count per period = 12.
- load p=3, s=4 -> cfg_err pulses once, p_act/s_act unchanged. Then load p=2, s=2 -> mod_out constantly 1, tc every 2nd cycle.
- en deasserted at cnt=1 with p=5 -> counting continues to cnt=4, tc pulses, then IDLE with busy=0 and outputs 0. Re-assert en=1 at cnt=3 in a second run -> no IDLE entry, periods uninterrupted.
- rst_n low for one cycle at cnt=3 -> all outputs 0 asynchronously, p_act=P_RST, pending cleared. Restart with en=1 -> period begins at cnt=0.
- With DIVCTRL_FRAC_EN, FRAC_W=8, p=4, s=1, frac_val=64 -> s_eff=2 exactly once in every 4 periods. Input-cycles per period: 9,9,9,10 repeating, average 9.25.
